// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard/sequencing controller for the 5-stage MIPS pipeline.
// Latency: all control outputs are combinational from shadow state and current inputs; the shadow
// scoreboard and stall counter update at the rising edge. d_busy freezes the whole pipe (backpressure).
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   fd_insn/fd_valid/fd_rwe/
//   fd_rdst/fd_load/fd_uses_rt   decoded attributes of the instruction in F/D
//   x_do_branch                  taken branch/jump resolved in execute
//   d_busy                       data memory busy; freezes the pipe
//   stall, dx_bubble, fd_flush,
//   freeze                       pipeline sequencing controls
//   fwd_a_sel, fwd_b_sel         execute operand bypass selects (00 RF, 01 MX, 10 WX)
//   stall_cycles                 saturating count of stalled cycles
//
// Build option: PIPELINE_HAZARD_CTRL_DELAY_SLOT_EN -- when defined the instruction in F/D at a taken
// branch is an architectural delay slot and is never flushed.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_insn,
  input  logic             fd_valid,
  input  logic             fd_rwe,
  input  logic             fd_rdst,
  input  logic             fd_load,
  input  logic             fd_uses_rt,
  input  logic             x_do_branch,
  input  logic             d_busy,
  output logic             stall,
  output logic             dx_bubble,
  output logic             fd_flush,
  output logic             freeze,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cycles
);

  // One shadow scoreboard entry per pipeline register.
  typedef struct packed {
    logic       v;
    logic       we;
    logic       ld;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
  } entry_t;

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_MX = 2'b01;
  localparam logic [1:0] SEL_WX = 2'b10;

  entry_t dx_q, xm_q, mw_q;
  entry_t dx_d, xm_d, mw_d;
  entry_t fd_ent;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       fd_rs, fd_rt, fd_dst;
  logic             lu, sq;

  // Opcode, shamt and funct fields carry no hazard information here.
  logic unused_bits;
`ifdef PIPELINE_HAZARD_CTRL_DELAY_SLOT_EN
  assign unused_bits = ^{fd_insn[31:26], fd_insn[10:0], x_do_branch};
`else
  assign unused_bits = ^{fd_insn[31:26], fd_insn[10:0]};
`endif

  function automatic logic match_f(entry_t s, logic [4:0] r);
    return s.v & s.we & (s.dst == r);
  endfunction

  // MX is checked first so the youngest producer wins. A load sitting in X/M has no data yet
  // on aluOut_XM, so it is never an MX source.
  function automatic logic [1:0] sel_f(entry_t xm, entry_t mw, logic [4:0] r);
    if (match_f(xm, r) && !xm.ld) return SEL_MX;
    else if (match_f(mw, r))      return SEL_WX;
    else                          return SEL_RF;
  endfunction

  // Decode the F/D instruction into a scoreboard entry; r0 is never a real destination.
  always_comb begin
    fd_rs         = fd_insn[25:21];
    fd_rt         = fd_insn[20:16];
    fd_dst        = fd_rdst ? fd_insn[15:11] : fd_insn[20:16];
    fd_ent        = '0;
    fd_ent.v      = fd_valid;
    fd_ent.we     = fd_rwe & (fd_dst != 5'd0);
    fd_ent.ld     = fd_load;
    fd_ent.dst    = fd_dst;
    fd_ent.rs     = fd_rs;
    fd_ent.rt     = fd_rt;
    fd_ent.use_rt = fd_uses_rt;
  end

  always_comb begin
    lu = dx_q.ld & (match_f(dx_q, fd_rs) | (fd_uses_rt & match_f(dx_q, fd_rt))) & fd_valid;
`ifdef PIPELINE_HAZARD_CTRL_DELAY_SLOT_EN
    sq = 1'b0;
`else
    sq = x_do_branch & ~d_busy;
`endif
  end

  // Sequencing priority: memory busy, then branch squash, then load-use.
  always_comb begin
    stall     = 1'b0;
    dx_bubble = 1'b0;
    fd_flush  = 1'b0;
    freeze    = 1'b0;
    dx_d      = fd_ent;
    xm_d      = dx_q;
    mw_d      = xm_q;
    if (d_busy) begin
      freeze = 1'b1;
      stall  = 1'b1;
      dx_d   = dx_q;
      xm_d   = xm_q;
      mw_d   = mw_q;
    end else if (sq) begin
      // The wrong-path instruction in F/D is dropped and the target is fetched next.
      fd_flush  = 1'b1;
      dx_bubble = 1'b1;
      dx_d      = '0;
    end else if (lu) begin
      stall     = 1'b1;
      dx_bubble = 1'b1;
      dx_d      = '0;
    end
  end

  // Bypass selects come from registered state only.
  always_comb begin
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    if (dx_q.v) begin
      fwd_a_sel = sel_f(xm_q, mw_q, dx_q.rs);
      if (dx_q.use_rt) fwd_b_sel = sel_f(xm_q, mw_q, dx_q.rt);
    end
  end

  // Saturating stall counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dx_q  <= '0;
      xm_q  <= '0;
      mw_q  <= '0;
      cnt_q <= '0;
    end else begin
      dx_q  <= dx_d;
      xm_q  <= xm_d;
      mw_q  <= mw_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scenarios plus randomized traffic for pipeline_hazard_ctrl.
// Expected values come from an instruction-level model of the pipe (raw instructions per stage).
// Honours PIPELINE_HAZARD_CTRL_DELAY_SLOT_EN the same way the design does.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset;
  logic [31:0]      fd_insn;
  logic             fd_valid, fd_rwe, fd_rdst, fd_load, fd_uses_rt;
  logic             x_do_branch, d_busy;
  logic             stall, dx_bubble, fd_flush, freeze;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .fd_insn(fd_insn), .fd_valid(fd_valid), .fd_rwe(fd_rwe),
    .fd_rdst(fd_rdst), .fd_load(fd_load), .fd_uses_rt(fd_uses_rt), .x_do_branch(x_do_branch),
    .d_busy(d_busy), .stall(stall), .dx_bubble(dx_bubble), .fd_flush(fd_flush), .freeze(freeze),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Each pipe slot holds the raw instruction as it appeared in F/D; index 0 = D/X, 1 = X/M, 2 = M/W.
  typedef struct packed {
    bit        valid, rwe, rdst, load, uses_rt;
    bit [31:0] insn;
  } rec_t;

  typedef struct packed {
    bit       stall, bubble, flush, freeze;
    bit [1:0] fa, fb;
  } exp_t;

  rec_t pipe[$];
  int   m_cnt;

  function automatic bit [4:0] dest_of(rec_t r);
    return r.rdst ? r.insn[15:11] : r.insn[20:16];
  endfunction

  // An instruction produces register reg only if it is real, writes, and the target is not r0.
  function automatic bit writes(rec_t r, bit [4:0] reg_n);
    return r.valid && r.rwe && (dest_of(r) != 5'd0) && (dest_of(r) == reg_n);
  endfunction

  function automatic bit [1:0] src_sel(rec_t xm, rec_t mw, bit [4:0] reg_n);
    if (writes(xm, reg_n) && !xm.load) return 2'd1;
    if (writes(mw, reg_n))             return 2'd2;
    return 2'd0;
  endfunction

  function automatic rec_t cur_rec();
    rec_t r;
    r.valid = fd_valid; r.rwe = fd_rwe; r.rdst = fd_rdst; r.load = fd_load;
    r.uses_rt = fd_uses_rt; r.insn = fd_insn;
    return r;
  endfunction

  function automatic exp_t expect_out();
    exp_t e;
    rec_t dx, xm, mw;
    bit   lu, sq;
    e  = '0;
    dx = pipe[0]; xm = pipe[1]; mw = pipe[2];
    lu = fd_valid && dx.load &&
         (writes(dx, fd_insn[25:21]) || (fd_uses_rt && writes(dx, fd_insn[20:16])));
`ifdef PIPELINE_HAZARD_CTRL_DELAY_SLOT_EN
    sq = 1'b0;
`else
    sq = x_do_branch && !d_busy;
`endif
    if (d_busy) begin
      e.freeze = 1'b1; e.stall = 1'b1;
    end else if (sq) begin
      e.flush = 1'b1; e.bubble = 1'b1;
    end else if (lu) begin
      e.stall = 1'b1; e.bubble = 1'b1;
    end
    if (dx.valid) begin
      e.fa = src_sel(xm, mw, dx.insn[25:21]);
      if (dx.uses_rt) e.fb = src_sel(xm, mw, dx.insn[20:16]);
    end
    return e;
  endfunction

  task automatic model_clear();
    pipe.delete();
    repeat (3) pipe.push_back('0);
    m_cnt = 0;
  endtask

  // Advance one clock; the model consumes the inputs that were stable across the edge.
  task automatic tick();
    exp_t e;
    rec_t nd;
    bit   rst_s, busy_s;
    e      = expect_out();
    nd     = cur_rec();
    rst_s  = reset;
    busy_s = d_busy;
    @(posedge clock);
    if (rst_s) model_clear();
    else begin
      if (e.stall && m_cnt < CNT_MAX) m_cnt++;
      if (!busy_s) begin
        if (e.bubble) nd = '0;
        pipe.push_front(nd);
        void'(pipe.pop_back());
      end
    end
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_alu(input int rd, input int rs, input int rt);
    fd_insn = {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd32};
    fd_valid = 1; fd_rwe = 1; fd_rdst = 1; fd_load = 0; fd_uses_rt = 1;
  endtask

  task automatic set_lw(input int rt, input int base);
    fd_insn = {6'h23, 5'(base), 5'(rt), 16'd0};
    fd_valid = 1; fd_rwe = 1; fd_rdst = 0; fd_load = 1; fd_uses_rt = 0;
  endtask

  task automatic set_beq(input int rs, input int rt);
    fd_insn = {6'h04, 5'(rs), 5'(rt), 16'h0010};
    fd_valid = 1; fd_rwe = 0; fd_rdst = 0; fd_load = 0; fd_uses_rt = 1;
  endtask

  task automatic set_nop();
    fd_insn = 32'd0;
    fd_valid = 0; fd_rwe = 0; fd_rdst = 0; fd_load = 0; fd_uses_rt = 0;
  endtask

  task automatic do_reset();
    reset = 1; x_do_branch = 0; d_busy = 0;
    set_nop();
    tick();
    reset = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++;
    if ({stall, dx_bubble, fd_flush, freeze} !== 4'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b expected=0000", {stall, dx_bubble, fd_flush, freeze});
    end
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0) begin
      failures++; $display("FAIL reset_fwd got=%b expected=0000", {fwd_a_sel, fwd_b_sel});
    end
    checks++;
    if (stall_cycles !== '0) begin
      failures++; $display("FAIL reset_cnt got=%0d expected=0", stall_cycles);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_alu(3, 1, 2); tick();
    set_alu(4, 3, 5);
    @(negedge clock);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL b2b_nostall got=%b expected=0", stall); end
    tick();
    set_nop();
    @(negedge clock);
    checks++;
    if (fwd_a_sel !== 2'b01) begin failures++; $display("FAIL b2b_mx got=%b expected=01", fwd_a_sel); end
    checks++;
    if (fwd_b_sel !== 2'b00) begin failures++; $display("FAIL b2b_b_rf got=%b expected=00", fwd_b_sel); end
    // One unrelated instruction between producer and consumer.
    do_reset();
    set_alu(3, 1, 2); tick();
    set_alu(7, 8, 9); tick();
    set_alu(4, 3, 5); tick();
    set_nop();
    @(negedge clock);
    checks++;
    if (fwd_a_sel !== 2'b10) begin failures++; $display("FAIL gap_wx got=%b expected=10", fwd_a_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_lw(8, 29); tick();
    set_alu(9, 8, 8);
    @(negedge clock);
    checks++;
    if ({stall, dx_bubble} !== 2'b11) begin
      failures++; $display("FAIL lu_stall got=%b expected=11", {stall, dx_bubble});
    end
    tick();
    @(negedge clock);
    checks++;
    if ({stall, dx_bubble} !== 2'b00) begin
      failures++; $display("FAIL lu_once got=%b expected=00", {stall, dx_bubble});
    end
    tick();
    set_nop();
    @(negedge clock);
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin
      failures++; $display("FAIL lu_wx got=%b expected=1010", {fwd_a_sel, fwd_b_sel});
    end
    checks++;
    if (stall_cycles !== 4'd1) begin failures++; $display("FAIL lu_cnt got=%0d expected=1", stall_cycles); end
  endtask

  task automatic test_reg0();
    do_reset();
    set_alu(0, 1, 2); tick();
    set_alu(5, 0, 0);
    @(negedge clock);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL r0_nostall got=%b expected=0", stall); end
    tick();
    set_lw(0, 29);
    @(negedge clock);
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0) begin
      failures++; $display("FAIL r0_alu_fwd got=%b expected=0000", {fwd_a_sel, fwd_b_sel});
    end
    tick();
    set_alu(5, 0, 0);
    @(negedge clock);
    checks++;
    if ({stall, dx_bubble} !== 2'b00) begin
      failures++; $display("FAIL r0_lw_nostall got=%b expected=00", {stall, dx_bubble});
    end
    tick();
    set_nop(); tick();
    @(negedge clock);
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0) begin
      failures++; $display("FAIL r0_lw_fwd got=%b expected=0000", {fwd_a_sel, fwd_b_sel});
    end
  endtask

  task automatic test_mem_busy();
    do_reset();
    set_lw(8, 29); tick();
    set_alu(9, 8, 8);
    d_busy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({freeze, stall, dx_bubble} !== 3'b110) begin
        failures++; $display("FAIL busy_freeze cyc=%0d got=%b expected=110", i, {freeze, stall, dx_bubble});
      end
      tick();
    end
    d_busy = 0;
    @(negedge clock);
    checks++;
    if ({freeze, stall, dx_bubble} !== 3'b011) begin
      failures++; $display("FAIL busy_then_lu got=%b expected=011", {freeze, stall, dx_bubble});
    end
    tick();
    @(negedge clock);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL busy_lu_once got=%b expected=0", stall); end
    tick();
    set_nop();
    @(negedge clock);
    checks++;
    if (fwd_a_sel !== 2'b10) begin failures++; $display("FAIL busy_wx got=%b expected=10", fwd_a_sel); end
    checks++;
    if (stall_cycles !== 4'd4) begin failures++; $display("FAIL busy_cnt got=%0d expected=4", stall_cycles); end
  endtask

  task automatic test_branch();
    do_reset();
    set_beq(1, 2); tick();
    set_alu(6, 1, 2);
    x_do_branch = 1;
    @(negedge clock);
    checks++;
`ifdef PIPELINE_HAZARD_CTRL_DELAY_SLOT_EN
    if ({fd_flush, dx_bubble, stall} !== 3'b000) begin
      failures++; $display("FAIL br_slot got=%b expected=000", {fd_flush, dx_bubble, stall});
    end
`else
    if ({fd_flush, dx_bubble, stall} !== 3'b110) begin
      failures++; $display("FAIL br_flush got=%b expected=110", {fd_flush, dx_bubble, stall});
    end
`endif
    tick();
    x_do_branch = 0;
    set_alu(7, 6, 6);
    @(negedge clock);
    checks++;
    if (fd_flush !== 1'b0) begin failures++; $display("FAIL br_one_cycle got=%b expected=0", fd_flush); end
    tick();
    set_nop();
    @(negedge clock);
    checks++;
`ifdef PIPELINE_HAZARD_CTRL_DELAY_SLOT_EN
    if (fwd_a_sel !== 2'b01) begin failures++; $display("FAIL br_slot_reaches_x got=%b expected=01", fwd_a_sel); end
`else
    if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL br_squashed got=%b expected=00", fwd_a_sel); end
`endif
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_lw(8, 29); tick();
    set_alu(9, 8, 8);
    d_busy = 1; tick();
    reset = 1; tick();
    reset = 0; d_busy = 0;
    @(negedge clock);
    checks++;
    if ({stall, dx_bubble, fd_flush, freeze, fwd_a_sel, fwd_b_sel} !== 8'b0) begin
      failures++;
      $display("FAIL rst_mid_outs got=%b expected=00000000",
               {stall, dx_bubble, fd_flush, freeze, fwd_a_sel, fwd_b_sel});
    end
    checks++;
    if (stall_cycles !== '0) begin failures++; $display("FAIL rst_mid_cnt got=%0d expected=0", stall_cycles); end
    tick();
    set_nop();
    @(negedge clock);
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0) begin
      failures++; $display("FAIL rst_mid_nofwd got=%b expected=0000", {fwd_a_sel, fwd_b_sel});
    end
  endtask

  task automatic test_saturation();
    do_reset();
    d_busy = 1;
    repeat (CNT_MAX + 6) tick();
    d_busy = 0;
    @(negedge clock);
    checks++;
    if (stall_cycles !== CNT_W'(CNT_MAX)) begin
      failures++; $display("FAIL cnt_saturate got=%0d expected=%0d", stall_cycles, CNT_MAX);
    end
  endtask

  task automatic test_random();
    exp_t e;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 99) < 2);
      d_busy      = ($urandom_range(0, 99) < 15);
      x_do_branch = ($urandom_range(0, 99) < 10);
      fd_valid    = ($urandom_range(0, 99) < 85);
      fd_load     = ($urandom_range(0, 99) < 30);
      fd_rwe      = ($urandom_range(0, 99) < 80);
      fd_rdst     = fd_load ? 1'b0 : 1'($urandom_range(0, 1));
      fd_uses_rt  = 1'($urandom_range(0, 1));
      fd_insn     = {6'($urandom), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                     5'($urandom_range(0, 5)), 11'($urandom)};
      @(negedge clock);
      e = expect_out();
      checks++;
      if ({stall, dx_bubble, fd_flush, freeze} !== {e.stall, e.bubble, e.flush, e.freeze}) begin
        failures++;
        $display("FAIL rnd_ctrl n=%0d got=%b expected=%b", n,
                 {stall, dx_bubble, fd_flush, freeze}, {e.stall, e.bubble, e.flush, e.freeze});
      end
      checks++;
      if ({fwd_a_sel, fwd_b_sel} !== {e.fa, e.fb}) begin
        failures++;
        $display("FAIL rnd_fwd n=%0d got=%b expected=%b", n, {fwd_a_sel, fwd_b_sel}, {e.fa, e.fb});
      end
      checks++;
      if (stall_cycles !== CNT_W'(m_cnt)) begin
        failures++; $display("FAIL rnd_cnt n=%0d got=%0d expected=%0d", n, stall_cycles, m_cnt);
      end
      tick();
    end
    reset = 0; d_busy = 0; x_do_branch = 0;
  endtask

  initial begin
    reset = 1; d_busy = 0; x_do_branch = 0;
    set_nop();
    model_clear();
    #1;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_reg0();
    test_mem_busy();
    test_branch();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
